// File: rtl/control_seq.sv
// Microcoded five-step fetch/execute sequencer driving the 16-bit datapath control word.
// Optional CONTROL_SEQ_EARLY_END_EN: skip trailing all-zero execute steps.
module control_seq (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  opcode,
    input  logic        flag_carry,
    input  logic        flag_zero,
    output logic [15:0] control_word,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [15:0] CwHalt     = 16'h0001;
    localparam logic [15:0] CwMarIn    = 16'h0002;
    localparam logic [15:0] CwRamIn    = 16'h0004;
    localparam logic [15:0] CwRamOut   = 16'h0008;
    localparam logic [15:0] CwIrOut    = 16'h0010;
    localparam logic [15:0] CwIrIn     = 16'h0020;
    localparam logic [15:0] CwAIn      = 16'h0040;
    localparam logic [15:0] CwAOut     = 16'h0080;
    localparam logic [15:0] CwSumOut   = 16'h0100;
    localparam logic [15:0] CwSubtract = 16'h0200;
    localparam logic [15:0] CwBIn      = 16'h0400;
    localparam logic [15:0] CwOutIn    = 16'h0800;
    localparam logic [15:0] CwPcEnable = 16'h1000;
    localparam logic [15:0] CwPcOut    = 16'h2000;
    localparam logic [15:0] CwJump     = 16'h4000;
    localparam logic [15:0] CwFlagsIn  = 16'h8000;

    typedef enum logic [2:0] {
        StFetch0 = 3'd0,
        StFetch1 = 3'd1,
        StExec2  = 3'd2,
        StExec3  = 3'd3,
        StExec4  = 3'd4
    } step_e;

    step_e       step_q;
    step_e       step_seq;
    step_e       step_d;
    logic        halted_q;
    logic [15:0] raw_word;

    function automatic logic [15:0] decode(input step_e s, input logic [3:0] op,
                                           input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        case (s)
            StFetch0: w = CwPcOut | CwMarIn;
            StFetch1: w = CwRamOut | CwIrIn | CwPcEnable;
            StExec2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: w = CwIrOut | CwMarIn;
                    4'h5: w = CwIrOut | CwAIn;
                    4'h6: w = CwIrOut | CwJump;
                    4'h7: w = c ? (CwIrOut | CwJump) : 16'h0000;
                    4'h8: w = z ? (CwIrOut | CwJump) : 16'h0000;
                    4'hE: w = CwAOut | CwOutIn;
                    4'hF: w = CwHalt;
                    default: w = 16'h0000;
                endcase
            end
            StExec3: begin
                case (op)
                    4'h1: w = CwRamOut | CwAIn;
                    4'h2, 4'h3: w = CwRamOut | CwBIn;
                    4'h4: w = CwAOut | CwRamIn;
                    default: w = 16'h0000;
                endcase
            end
            StExec4: begin
                case (op)
                    4'h2: w = CwSumOut | CwAIn | CwFlagsIn;
                    4'h3: w = CwSumOut | CwSubtract | CwAIn | CwFlagsIn;
                    default: w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_comb begin
        raw_word = decode(step_q, opcode, flag_carry, flag_zero);
        case (step_q)
            StFetch0: step_seq = StFetch1;
            StFetch1: step_seq = StExec2;
            StExec2:  step_seq = StExec3;
            StExec3:  step_seq = StExec4;
            default:  step_seq = StFetch0;
        endcase
        step_d = step_seq;
`ifdef CONTROL_SEQ_EARLY_END_EN
        // Only from step 2 on: the opcode is stale until IR loads at the end of step 1.
        if ((step_q == StExec2 || step_q == StExec3) &&
            decode(step_seq, opcode, flag_carry, flag_zero) == 16'h0000) begin
            step_d = StFetch0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            step_q   <= StFetch0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (raw_word[0]) begin
                halted_q <= 1'b1;
            end else begin
                step_q <= step_d;
            end
        end
    end

    assign control_word = halted_q ? CwHalt : raw_word;
    assign step         = step_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed-vector bench for control_seq; expected words hand-derived from the control bit map.
module tb_control_seq;

    logic        clk;
    logic        clear;
    logic [3:0]  opcode;
    logic        flag_carry;
    logic        flag_zero;
    logic [15:0] control_word;
    logic [2:0]  step;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    control_seq dut (
        .clk          (clk),
        .clear        (clear),
        .opcode       (opcode),
        .flag_carry   (flag_carry),
        .flag_zero    (flag_zero),
        .control_word (control_word),
        .step         (step),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp_step,
                               input logic exp_halted, input logic [15:0] exp_word);
        check_eq({tag, ".step"}, {13'd0, step}, {13'd0, exp_step});
        check_eq({tag, ".halted"}, {15'd0, halted}, {15'd0, exp_halted});
        check_eq({tag, ".word"}, control_word, exp_word);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] w2;
        logic [15:0] w3;
        logic [15:0] w4;
        int          len_early;
    } vec_t;

    vec_t vecs[$] = '{
        '{"nop",   4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3},
        '{"lda",   4'h1, 1'b0, 1'b0, 16'h0012, 16'h0048, 16'h0000, 4},
        '{"add",   4'h2, 1'b0, 1'b0, 16'h0012, 16'h0408, 16'h8140, 5},
        '{"sub",   4'h3, 1'b1, 1'b1, 16'h0012, 16'h0408, 16'h8340, 5},
        '{"sta",   4'h4, 1'b0, 1'b0, 16'h0012, 16'h0084, 16'h0000, 4},
        '{"ldi",   4'h5, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 3},
        '{"jmp",   4'h6, 1'b0, 1'b0, 16'h4010, 16'h0000, 16'h0000, 3},
        '{"jc_t",  4'h7, 1'b1, 1'b0, 16'h4010, 16'h0000, 16'h0000, 3},
        '{"jc_n",  4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3},
        '{"jz_t",  4'h8, 1'b0, 1'b1, 16'h4010, 16'h0000, 16'h0000, 3},
        '{"jz_n",  4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3},
        '{"out",   4'hE, 1'b0, 1'b0, 16'h0880, 16'h0000, 16'h0000, 3},
        '{"op_a",  4'hA, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3}
    };

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    // Expects to be entered at step 0; fetch steps are driven with a misleading opcode.
    task automatic run_vec(input vec_t v);
        logic [15:0] w [2:4];
        int          last;
        w[2] = v.w2;
        w[3] = v.w3;
        w[4] = v.w4;
`ifdef CONTROL_SEQ_EARLY_END_EN
        last = v.len_early - 1;
`else
        last = 4;
`endif
        opcode     = 4'hF;
        flag_carry = ~v.c;
        flag_zero  = ~v.z;
        check_state({v.name, ".s0"}, 3'd0, 1'b0, 16'h2002);
        cyc();
        check_state({v.name, ".s1"}, 3'd1, 1'b0, 16'h1028);
        opcode     = v.op;
        flag_carry = v.c;
        flag_zero  = v.z;
        cyc();
        for (int s = 2; s <= last; s++) begin
            check_state({v.name, $sformatf(".s%0d", s)}, 3'(s), 1'b0, w[s]);
            cyc();
        end
        check_eq({v.name, ".wrap"}, {13'd0, step}, 16'd0);
    endtask

    initial begin
        clear      = 1'b0;
        opcode     = 4'h0;
        flag_carry = 1'b0;
        flag_zero  = 1'b0;
        cyc();
        do_clear();
        check_state("reset", 3'd0, 1'b0, 16'h2002);

        foreach (vecs[i]) run_vec(vecs[i]);

        // HLT: freeze at step 2 regardless of later opcode/flag activity.
        opcode = 4'hF;
        cyc();
        cyc();
        check_state("hlt.s2", 3'd2, 1'b0, 16'h0001);
        cyc();
        check_state("hlt.stop", 3'd2, 1'b1, 16'h0001);
        opcode = 4'h1;
        for (int i = 0; i < 20; i++) begin
            flag_carry = i[0];
            flag_zero  = i[1];
            cyc();
            check_state($sformatf("hlt.hold%0d", i), 3'd2, 1'b1, 16'h0001);
        end
        do_clear();
        check_state("clr_halt", 3'd0, 1'b0, 16'h2002);

        // Clear during step 3 of LDA abandons the instruction.
        opcode = 4'h1;
        cyc();
        cyc();
        cyc();
        check_state("lda_mid.s3", 3'd3, 1'b0, 16'h0048);
        do_clear();
        check_state("clr_mid", 3'd0, 1'b0, 16'h2002);

        // Clear coinciding with the HLT step wins over the halt.
        opcode = 4'hF;
        cyc();
        cyc();
        check_state("hlt2.s2", 3'd2, 1'b0, 16'h0001);
        do_clear();
        check_state("clr_vs_hlt", 3'd0, 1'b0, 16'h2002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
